// File: rtl/led_fade_pwm_pkg.sv
// Shared definitions for the LED fade PWM block: per-channel fade state encoding.
package led_fade_pwm_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_UP   = 2'd1,
    ST_ON   = 2'd2,
    ST_DOWN = 2'd3
  } fade_state_e;

endpackage

// File: rtl/led_fade_pwm_channel.sv
// One LED channel: fade FSM, saturating duty register, PWM comparator and
// registered PWM/BUSY drive.
module led_fade_channel
  import led_fade_pwm_pkg::*;
#(
  parameter int PWM_BITS  = 8,
  parameter int RAMP_STEP = 1
) (
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic                STEP,
  input  logic [PWM_BITS-1:0] PWM_CNT,
  input  logic                REQ,
  output logic                PWM,
  output logic                BUSY
);

  localparam logic [PWM_BITS:0] STEP_W = (PWM_BITS+1)'(RAMP_STEP);

  // Carry out of the widened sum means the result passed MAX.
  function automatic logic [PWM_BITS-1:0] sat_add(input logic [PWM_BITS-1:0] d);
    logic [PWM_BITS:0] s;
    s = {1'b0, d} + STEP_W;
    return s[PWM_BITS] ? '1 : s[PWM_BITS-1:0];
  endfunction

  function automatic logic [PWM_BITS-1:0] sat_sub(input logic [PWM_BITS-1:0] d);
    logic signed [PWM_BITS:0] s;
    s = $signed({1'b0, d}) - $signed(STEP_W);
    return s[PWM_BITS] ? '0 : s[PWM_BITS-1:0];
  endfunction

  fade_state_e         state_p0, state_nxt;
  logic [PWM_BITS-1:0] duty_p0, duty_nxt;
  logic                pwm_nxt, busy_nxt;

  // Stage p0: state and duty registers
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_p0 <= ST_OFF;
      duty_p0  <= '0;
    end else begin
      state_p0 <= state_nxt;
      duty_p0  <= duty_nxt;
    end
  end

  // Duty follows the current state on a step; a request reversal wins over completion.
  always_comb begin
    state_nxt = state_p0;
    duty_nxt  = duty_p0;
    case (state_p0)
      ST_OFF: begin
        duty_nxt = '0;
        if (REQ) state_nxt = ST_UP;
      end
      ST_UP: begin
        if (STEP) duty_nxt = sat_add(duty_p0);
        if (!REQ) state_nxt = ST_DOWN;
        else if (STEP && (duty_nxt == '1)) state_nxt = ST_ON;
      end
      ST_ON: begin
        duty_nxt = '1;
        if (!REQ) state_nxt = ST_DOWN;
      end
      ST_DOWN: begin
        if (STEP) duty_nxt = sat_sub(duty_p0);
        if (REQ) state_nxt = ST_UP;
        else if (STEP && (duty_nxt == '0)) state_nxt = ST_OFF;
      end
      default: state_nxt = ST_OFF;
    endcase
  end

  always_comb begin
    pwm_nxt  = 1'b0;
    busy_nxt = 1'b0;
    case (state_p0)
      ST_ON: pwm_nxt = 1'b1;
      ST_UP, ST_DOWN: begin
        pwm_nxt  = (PWM_CNT < duty_p0);
        busy_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  // Stage p1: registered pin drive
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      PWM  <= 1'b0;
      BUSY <= 1'b0;
    end else begin
      PWM  <= pwm_nxt;
      BUSY <= busy_nxt;
    end
  end

endmodule

// File: rtl/led_fade_pwm.sv
// LED fade PWM top: shared PWM period counter and ramp-step divider feeding
// independent per-channel fade engines.
module led_fade_pwm
  import led_fade_pwm_pkg::*;
#(
  parameter int CHANNELS  = 2,
  parameter int PWM_BITS  = 8,
  parameter int RAMP_STEP = 1,
  parameter int STEP_DIV  = 4
) (
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic                TICK,
  input  logic [CHANNELS-1:0] LED_REQ,
  output logic [CHANNELS-1:0] LED_PWM,
  output logic [CHANNELS-1:0] BUSY
);

  localparam int              SC_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(STEP_DIV - 1);

  logic [PWM_BITS-1:0] pwm_cnt_p0;
  logic [SC_W-1:0]     step_cnt_p0;
  logic [CHANNELS-1:0] req_p0;
  logic                wrap, step;

  assign wrap = TICK && (pwm_cnt_p0 == '1);
  assign step = wrap && (step_cnt_p0 == SC_LAST);

  // Stage p0: shared timebase and request capture
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      pwm_cnt_p0  <= '0;
      step_cnt_p0 <= '0;
      req_p0      <= '0;
    end else begin
      req_p0 <= LED_REQ;
      if (TICK) pwm_cnt_p0 <= pwm_cnt_p0 + 1'b1;
      if (wrap) step_cnt_p0 <= (step_cnt_p0 == SC_LAST) ? '0 : step_cnt_p0 + 1'b1;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    led_fade_channel #(
      .PWM_BITS (PWM_BITS),
      .RAMP_STEP(RAMP_STEP)
    ) u_ch (
      .CLOCK  (CLOCK),
      .RESET  (RESET),
      .STEP   (step),
      .PWM_CNT(pwm_cnt_p0),
      .REQ    (req_p0[c]),
      .PWM    (LED_PWM[c]),
      .BUSY   (BUSY[c])
    );
  end

endmodule

// File: tb/tb_led_fade_pwm.sv
// Bench for led_fade_pwm: two instances (ramp step 1 and 4) with a per-cycle
// behavioural model plus hand-computed per-period high counts.
module tb_led_fade_pwm;

  localparam int MAXV = 15;
  localparam int SDIV = 1;
  localparam int IDLE = 0, RISE = 1, FULL = 2, FALL = 3;
  localparam int RS [2] = '{1, 4};

  logic       CLOCK, RESET, TICK;
  logic [1:0] LED_REQ;
  logic [1:0] pwm_a, pwm_b, busy_a, busy_b;

  int n_pass = 0, n_total = 0;
  int m_cnt, m_cnt_old, m_tick_old, m_sc;
  int m_req [2];
  int m_mode [2][2];
  int m_duty [2][2];
  int m_pwm  [2][2];
  int m_busy [2][2];
  int win_q [2][$];
  int acc [2];
  bit win_clr = 1'b0;
  bit chk_en = 1'b0;
  int e [16];
  int cyc;

  led_fade_pwm #(.CHANNELS(2), .PWM_BITS(4), .RAMP_STEP(1), .STEP_DIV(1)) dut_a (
    .CLOCK(CLOCK), .RESET(RESET), .TICK(TICK), .LED_REQ(LED_REQ),
    .LED_PWM(pwm_a), .BUSY(busy_a));

  led_fade_pwm #(.CHANNELS(2), .PWM_BITS(4), .RAMP_STEP(4), .STEP_DIV(1)) dut_b (
    .CLOCK(CLOCK), .RESET(RESET), .TICK(TICK), .LED_REQ(LED_REQ),
    .LED_PWM(pwm_b), .BUSY(busy_b));

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic logic [1:0] pwm_of(input int d);
    return (d == 0) ? pwm_a : pwm_b;
  endfunction

  function automatic logic [1:0] busy_of(input int d);
    return (d == 0) ? busy_a : busy_b;
  endfunction

  // Reference model: one update per rising edge from the levels present at that edge.
  task automatic model_step();
    int wrap, step, nd;
    if (RESET === 1'b1) begin
      m_cnt = 0; m_sc = 0; m_cnt_old = 0; m_tick_old = 0;
      m_req[0] = 0; m_req[1] = 0;
      for (int d = 0; d < 2; d++)
        for (int c = 0; c < 2; c++) begin
          m_mode[d][c] = IDLE; m_duty[d][c] = 0; m_pwm[d][c] = 0; m_busy[d][c] = 0;
        end
    end else begin
      wrap = (TICK === 1'b1 && m_cnt == MAXV) ? 1 : 0;
      step = (wrap != 0 && m_sc == SDIV - 1) ? 1 : 0;
      for (int d = 0; d < 2; d++)
        for (int c = 0; c < 2; c++) begin
          m_pwm[d][c]  = (m_mode[d][c] == FULL) ? 1 :
                         (m_mode[d][c] == IDLE) ? 0 : ((m_cnt < m_duty[d][c]) ? 1 : 0);
          m_busy[d][c] = (m_mode[d][c] == RISE || m_mode[d][c] == FALL) ? 1 : 0;
          nd = m_duty[d][c];
          if (step != 0 && m_mode[d][c] == RISE)
            nd = (m_duty[d][c] + RS[d] > MAXV) ? MAXV : m_duty[d][c] + RS[d];
          if (step != 0 && m_mode[d][c] == FALL)
            nd = (m_duty[d][c] - RS[d] < 0) ? 0 : m_duty[d][c] - RS[d];
          case (m_mode[d][c])
            IDLE: if (m_req[c] != 0) m_mode[d][c] = RISE;
            RISE: if (m_req[c] == 0) m_mode[d][c] = FALL;
                  else if (step != 0 && nd == MAXV) m_mode[d][c] = FULL;
            FULL: if (m_req[c] == 0) m_mode[d][c] = FALL;
            default: if (m_req[c] != 0) m_mode[d][c] = RISE;
                     else if (step != 0 && nd == 0) m_mode[d][c] = IDLE;
          endcase
          m_duty[d][c] = nd;
        end
      m_cnt_old  = m_cnt;
      m_tick_old = (TICK === 1'b1) ? 1 : 0;
      if (TICK === 1'b1) m_cnt = (m_cnt + 1) % (MAXV + 1);
      if (wrap != 0) m_sc = (m_sc + 1) % SDIV;
      m_req[0] = (LED_REQ[0] === 1'b1) ? 1 : 0;
      m_req[1] = (LED_REQ[1] === 1'b1) ? 1 : 0;
    end
  endtask

  task automatic compare();
    logic [1:0] p, b;
    for (int d = 0; d < 2; d++) begin
      p = pwm_of(d);
      b = busy_of(d);
      for (int c = 0; c < 2; c++) begin
        chk($sformatf("pwm_d%0d_c%0d", d, c), 32'(p[c]), m_pwm[d][c]);
        chk($sformatf("busy_d%0d_c%0d", d, c), 32'(b[c]), m_busy[d][c]);
      end
      acc[d] += (p[0] === 1'b1) ? 1 : 0;
    end
    // The output just seen was produced from pwm_cnt==MAX: a PWM period is complete.
    if (m_tick_old != 0 && m_cnt_old == MAXV) begin
      for (int d = 0; d < 2; d++) begin
        if (win_clr) win_q[d].delete();
        else win_q[d].push_back(acc[d]);
        acc[d] = 0;
      end
      win_clr = 1'b0;
    end
  endtask

  initial forever begin
    @(posedge CLOCK);
    model_step();
  end

  initial forever begin
    @(negedge CLOCK);
    if (chk_en) compare();
  end

  task automatic sync_mid();
    int k;
    k = 0;
    while (m_cnt != 4 && k < 64) begin
      @(negedge CLOCK);
      k++;
    end
    chk("sync_mid_reached", (m_cnt == 4) ? 1 : 0, 1);
  endtask

  task automatic wait_duty(input int val, input int lim, output int cycles);
    int k;
    k = 0;
    while (m_duty[0][0] != val && k < lim) begin
      @(negedge CLOCK);
      k++;
    end
    cycles = k;
    chk($sformatf("duty_reach_%0d", val), (m_duty[0][0] == val) ? 1 : 0, 1);
  endtask

  task automatic chk_win(input int d, input string nm, input int n);
    chk({nm, "_periods"}, (win_q[d].size() >= n) ? 1 : 0, 1);
    for (int i = 0; i < n; i++)
      chk($sformatf("%s[%0d]", nm, i), (i < win_q[d].size()) ? win_q[d][i] : -1, e[i]);
  endtask

  initial begin
    RESET = 1'b1; TICK = 1'b1; LED_REQ = 2'b11;
    acc[0] = 0; acc[1] = 0;

    // Test 1: reset with requests asserted
    for (int i = 0; i < 3; i++) begin
      @(negedge CLOCK);
      chk_en = 1'b1;
      chk("rst_pwm_a", 32'(pwm_a), 0);  chk("rst_busy_a", 32'(busy_a), 0);
      chk("rst_pwm_b", 32'(pwm_b), 0);  chk("rst_busy_b", 32'(busy_b), 0);
    end
    RESET = 1'b0;
    @(negedge CLOCK);
    chk("post_rst_pwm_a", 32'(pwm_a), 0);  chk("post_rst_busy_a", 32'(busy_a), 0);
    LED_REQ = 2'b00;
    repeat (64) @(negedge CLOCK);
    chk("settle_busy_a", 32'(busy_a), 0);

    // Test 2 / 4 up: channel 0 ramps from off to steady on
    sync_mid();
    LED_REQ = 2'b01; win_clr = 1'b1;
    repeat (100) @(negedge CLOCK);
    chk("ramp_busy_a", 32'(busy_a), 2'b01);
    repeat (200) @(negedge CLOCK);
    e = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 16, 0};
    chk_win(0, "up_a", 15);
    e = '{4, 8, 12, 16, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    chk_win(1, "up_b", 4);
    chk("on_busy_a", 32'(busy_a), 0);
    chk("on_busy_b", 32'(busy_b), 0);
    for (int i = 0; i < 16; i++) begin
      @(negedge CLOCK);
      chk("on_pwm_a", 32'(pwm_a), 2'b01);
    end

    // Test 4 down: full-scale fade to off
    sync_mid();
    LED_REQ = 2'b00; win_clr = 1'b1;
    repeat (300) @(negedge CLOCK);
    e = '{14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 0};
    chk_win(0, "down_a", 15);
    e = '{11, 7, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    chk_win(1, "down_b", 4);
    chk("off_pwm_a", 32'(pwm_a), 0);
    chk("off_busy_a", 32'(busy_a), 0);

    // Test 3: reverse at duty 6
    sync_mid();
    LED_REQ = 2'b01;
    wait_duty(6, 200, cyc);
    repeat (3) @(negedge CLOCK);
    LED_REQ = 2'b00; win_clr = 1'b1;
    repeat (150) @(negedge CLOCK);
    e = '{5, 4, 3, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    chk_win(0, "rev_a", 6);
    e = '{11, 7, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    chk_win(1, "rev_b", 4);
    chk("rev_off_pwm_a", 32'(pwm_a), 0);

    // Test 5: TICK held low mid-ramp
    sync_mid();
    LED_REQ = 2'b11;
    wait_duty(3, 200, cyc);
    repeat (5) @(negedge CLOCK);
    chk("freeze_cnt_model", m_cnt, 5);
    TICK = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLOCK);
      chk("freeze_pwm_a", 32'(pwm_a), 2'b00);
      chk("freeze_pwm_b", 32'(pwm_b), 2'b11);
      chk("freeze_busy_a", 32'(busy_a), 2'b11);
      chk("freeze_busy_b", 32'(busy_b), 2'b11);
    end
    TICK = 1'b1;
    wait_duty(4, 64, cyc);
    chk("resume_cycles_to_step", cyc, 11);

    // Test 6: reset pulse while both channels ramp
    repeat (20) @(negedge CLOCK);
    chk("pre_rst_busy_a", 32'(busy_a), 2'b11);
    RESET = 1'b1;
    @(negedge CLOCK);
    chk("midrst_pwm_a", 32'(pwm_a), 0);  chk("midrst_busy_a", 32'(busy_a), 0);
    chk("midrst_pwm_b", 32'(pwm_b), 0);  chk("midrst_busy_b", 32'(busy_b), 0);
    RESET = 1'b0;
    repeat (40) @(negedge CLOCK);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
